// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and widths for the instruction fetch slice.
// Consumed by the fetch interface, the PC register and the fetch unit top.
package risc_fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_HI = 2'b00,
        FETCH_LO = 2'b01,
        HOLD     = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the memory, decode-handshake and redirect signals around the fetch unit.
// master = fetch unit side, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
    import risc_fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [7:0]         imem_data;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic               halted;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  branch_taken,
        input  branch_target,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output branch_taken,
        output branch_target,
        input  halted
    );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: increments by two per instruction, loads even-aligned redirect targets.
module fetch_pc_reg
    import risc_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_RESET = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // A redirect outranks the sequential advance; wrap-around is the natural modulo add.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr & ~ADDR_W'(1);
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Two-byte instruction fetch FSM with valid/ready output and branch redirect.
// Optional macro FETCH_HALT_EN: an all-zero word stops fetch until the next branch.
module instr_fetch_unit
    import risc_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_RESET = 8'h00
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);

    fetch_state_t       state_q, state_d;
    logic [7:0]         hi_byte_q, hi_byte_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0]  pc;
    logic               pc_inc;
    logic               pc_load;
    logic [INSTR_W-1:0] fetched_word;
`ifdef FETCH_HALT_EN
    logic               halted_q, halted_d;
`endif

    fetch_pc_reg #(.PC_RESET(PC_RESET)) u_pc (
        .clk       (clk),
        .reset     (reset),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_addr (bus.branch_target),
        .pc        (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // A halted unit parks in HOLD with valid low, so only a branch can move it on.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_HI: state_d = FETCH_LO;
            FETCH_LO: state_d = HOLD;
            HOLD:     if (instr_valid_q && bus.instr_ready) state_d = FETCH_HI;
            default:  state_d = FETCH_HI;
        endcase
        if (bus.branch_taken) begin
            state_d = FETCH_HI;
        end
    end

    always_comb begin
        bus.imem_addr = pc;
        if (state_q == FETCH_LO) begin
            bus.imem_addr = pc + ADDR_W'(1);
        end
    end

    assign fetched_word = {hi_byte_q, bus.imem_data};

    always_comb begin
        hi_byte_d     = hi_byte_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_inc        = 1'b0;
        pc_load       = bus.branch_taken;
`ifdef FETCH_HALT_EN
        halted_d      = halted_q;
`endif
        if (bus.branch_taken) begin
            instr_valid_d = 1'b0;
`ifdef FETCH_HALT_EN
            halted_d      = 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH_HI: hi_byte_d = bus.imem_data;
                FETCH_LO: begin
`ifdef FETCH_HALT_EN
                    if (fetched_word == HALT_WORD) begin
                        halted_d = 1'b1;
                    end else begin
                        instr_d       = fetched_word;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                    end
`else
                    instr_d       = fetched_word;
                    instr_pc_d    = pc;
                    instr_valid_d = 1'b1;
`endif
                end
                HOLD: begin
                    if (instr_valid_q && bus.instr_ready) begin
                        instr_valid_d = 1'b0;
                        pc_inc        = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_byte_q     <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            hi_byte_q     <= hi_byte_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_HALT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign bus.halted = halted_q;
`else
    assign bus.halted = 1'b0;
`endif

    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, back-pressure, redirects,
// PC wrap, asynchronous reset and the FETCH_HALT_EN halt word.
module tb_instr_fetch_unit;

    logic clk;
    logic reset;
    logic [7:0] mem [256];
    int check_count;
    int error_count;

    instr_fetch_unit_if bus0 ();
    instr_fetch_unit_if bus1 ();

    instr_fetch_unit #(.PC_RESET(8'h00)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    instr_fetch_unit #(.PC_RESET(8'hFE)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    assign bus0.imem_data     = mem[bus0.imem_addr];
    assign bus1.imem_data     = mem[bus1.imem_addr];
    assign bus1.instr_ready   = 1'b1;
    assign bus1.branch_taken  = 1'b0;
    assign bus1.branch_target = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic branch, input logic [7:0] target);
        bus0.instr_ready   = ready;
        bus0.branch_taken  = branch;
        bus0.branch_target = target;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h03; mem[1] = 8'h45; mem[2] = 8'h04; mem[3] = 8'h65;
        mem[6] = 8'h07; mem[7] = 8'hD6; mem[8] = 8'h12; mem[9] = 8'h34;
        mem[8'hFE] = 8'hAB; mem[8'hFF] = 8'hCD;

        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("rst_valid", 32'(bus0.instr_valid), 32'd0);
        checkOutput("rst_addr", 32'(bus0.imem_addr), 32'h00);
        checkOutput("rst_instr", 32'(bus0.instr), 32'h0000);
        checkOutput("rst_pc", 32'(bus0.instr_pc), 32'h00);
        checkOutput("rst_halted", 32'(bus0.halted), 32'd0);
        checkOutput("rst_addr_fe", 32'(bus1.imem_addr), 32'hFE);
        reset = 1'b0;

        // Back-to-back fetch with ready held high
        tick();
        checkOutput("seq_lo_addr", 32'(bus0.imem_addr), 32'h01);
        checkOutput("seq_lo_valid", 32'(bus0.instr_valid), 32'd0);
        checkOutput("wrap_lo_addr", 32'(bus1.imem_addr), 32'hFF);
        tick();
        checkOutput("seq_w0_valid", 32'(bus0.instr_valid), 32'd1);
        checkOutput("seq_w0_instr", 32'(bus0.instr), 32'h0345);
        checkOutput("seq_w0_pc", 32'(bus0.instr_pc), 32'h00);
        checkOutput("wrap_valid", 32'(bus1.instr_valid), 32'd1);
        checkOutput("wrap_instr", 32'(bus1.instr), 32'hABCD);
        checkOutput("wrap_pc", 32'(bus1.instr_pc), 32'hFE);
        tick();
        checkOutput("seq_gap1_valid", 32'(bus0.instr_valid), 32'd0);
        checkOutput("seq_next_addr", 32'(bus0.imem_addr), 32'h02);
        checkOutput("wrap_next_addr", 32'(bus1.imem_addr), 32'h00);
        tick();
        checkOutput("seq_gap2_valid", 32'(bus0.instr_valid), 32'd0);
        tick();
        checkOutput("seq_w1_valid", 32'(bus0.instr_valid), 32'd1);
        checkOutput("seq_w1_instr", 32'(bus0.instr), 32'h0465);
        checkOutput("seq_w1_pc", 32'(bus0.instr_pc), 32'h02);
        tick();
        checkOutput("seq_w1_drop", 32'(bus0.instr_valid), 32'd0);
        checkOutput("seq_addr4", 32'(bus0.imem_addr), 32'h04);

        // Redirect to 0, then stall the first word for five cycles
        applyStimulus(1'b0, 1'b1, 8'h00);
        tick();
        checkOutput("br0_addr", 32'(bus0.imem_addr), 32'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("stall_first_valid", 32'(bus0.instr_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_valid", 32'(bus0.instr_valid), 32'd1);
            checkOutput("stall_instr", 32'(bus0.instr), 32'h0345);
            checkOutput("stall_addr", 32'(bus0.imem_addr), 32'h00);
        end
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("stall_accept_valid", 32'(bus0.instr_valid), 32'd0);
        checkOutput("stall_accept_addr", 32'(bus0.imem_addr), 32'h02);

        // Branch to 7 during FETCH_LO of the word at 2
        tick();
        checkOutput("brlo_addr", 32'(bus0.imem_addr), 32'h03);
        applyStimulus(1'b1, 1'b1, 8'h07);
        tick();
        checkOutput("brlo_valid", 32'(bus0.instr_valid), 32'd0);
        checkOutput("brlo_target_addr", 32'(bus0.imem_addr), 32'h06);
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("brlo_gap_valid", 32'(bus0.instr_valid), 32'd0);
        tick();
        checkOutput("brlo_w_valid", 32'(bus0.instr_valid), 32'd1);
        checkOutput("brlo_w_instr", 32'(bus0.instr), 32'h07D6);
        checkOutput("brlo_w_pc", 32'(bus0.instr_pc), 32'h06);
        tick();
        checkOutput("brlo_next_addr", 32'(bus0.imem_addr), 32'h08);

        // Handshake and branch in the same cycle: redirect wins over pc+2
        tick();
        tick();
        checkOutput("hsbr_w_instr", 32'(bus0.instr), 32'h1234);
        checkOutput("hsbr_w_valid", 32'(bus0.instr_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'h00);
        tick();
        checkOutput("hsbr_valid", 32'(bus0.instr_valid), 32'd0);
        checkOutput("hsbr_addr", 32'(bus0.imem_addr), 32'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("hsbr_redeliver", 32'(bus0.instr), 32'h0345);
        tick();

        // Reach the zero word at 10..11
        applyStimulus(1'b1, 1'b1, 8'h08);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("w8_instr", 32'(bus0.instr), 32'h1234);
        tick();
        checkOutput("w10_addr", 32'(bus0.imem_addr), 32'h0A);
        tick();
        tick();
`ifdef FETCH_HALT_EN
        checkOutput("halt_valid", 32'(bus0.instr_valid), 32'd0);
        checkOutput("halt_flag", 32'(bus0.halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("halt_hold_flag", 32'(bus0.halted), 32'd1);
            checkOutput("halt_hold_valid", 32'(bus0.instr_valid), 32'd0);
            checkOutput("halt_hold_addr", 32'(bus0.imem_addr), 32'h0A);
        end
        applyStimulus(1'b1, 1'b1, 8'h00);
        tick();
        checkOutput("unhalt_flag", 32'(bus0.halted), 32'd0);
        checkOutput("unhalt_addr", 32'(bus0.imem_addr), 32'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("unhalt_valid", 32'(bus0.instr_valid), 32'd1);
        checkOutput("unhalt_instr", 32'(bus0.instr), 32'h0345);
`else
        checkOutput("zero_valid", 32'(bus0.instr_valid), 32'd1);
        checkOutput("zero_instr", 32'(bus0.instr), 32'h0000);
        checkOutput("zero_pc", 32'(bus0.instr_pc), 32'h0A);
        checkOutput("zero_halted", 32'(bus0.halted), 32'd0);
        tick();
        checkOutput("zero_next_addr", 32'(bus0.imem_addr), 32'h0C);
`endif

        // Asynchronous reset in the middle of FETCH_LO
        applyStimulus(1'b1, 1'b1, 8'h00);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        checkOutput("arst_pre_addr", 32'(bus0.imem_addr), 32'h01);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(bus0.instr_valid), 32'd0);
        checkOutput("arst_addr", 32'(bus0.imem_addr), 32'h00);
        checkOutput("arst_addr_fe", 32'(bus1.imem_addr), 32'hFE);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("arst_restart_lo", 32'(bus0.imem_addr), 32'h01);
        tick();
        checkOutput("arst_restart_valid", 32'(bus0.instr_valid), 32'd1);
        checkOutput("arst_restart_instr", 32'(bus0.instr), 32'h0345);
        checkOutput("arst_restart_pc", 32'(bus0.instr_pc), 32'h00);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the byte-wide combinational instruction memory. It drives the 8-bit byte address and assembles each 16-bit instruction from two consecutive bytes: the even address supplies the high byte and the odd address the low byte. It presents each instruction to decode through a valid/ready handshake and accepts branch redirects from downstream.

Parameters:
ADDR_W, 8, width of the program counter and the memory byte address
INSTR_W, 16, width of the assembled instruction; always 2 x 8-bit bytes
PC_RESET, 8'h00, program counter value after reset; must be even

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_addr  output  ADDR_W  byte address to the instruction memory
imem_data  input  8  byte returned combinationally for imem_addr
instr  output  INSTR_W  assembled instruction, {high byte, low byte}
instr_pc  output  ADDR_W  even byte address the instruction was fetched from
instr_valid  output  1  instr and instr_pc are valid
instr_ready  input  1  decode accepts the instruction this cycle
branch_taken  input  1  single-cycle redirect request
branch_target  input  ADDR_W  redirect address; bit 0 is forced to 0
halted  output  1  fetch stopped (tied 0 when the optional feature is absent)

Behaviour:
- States: FETCH_HI, FETCH_LO, HOLD (2-bit encoding).
- Reset (async, asynchronous assert): pc=PC_RESET, state=FETCH_HI, hi_byte=0, instr=0, instr_pc=0, instr_valid=0, halted=0.
- imem_addr is combinational from state:
  - pc in FETCH_HI.
  - pc+1 in FETCH_LO.
  - pc in HOLD (don't-care, held stable).
- FETCH_HI: hi_byte<=imem_data; next state FETCH_LO.
- FETCH_LO: instr<={hi_byte,imem_data}; instr_pc<=pc; instr_valid<=1; next state HOLD.
- HOLD: instr, instr_pc and instr_valid are held stable while instr_ready=0.
  - On instr_valid&&instr_ready: instr_valid<=0; pc<=pc+2; next state FETCH_HI.
- Timing:
  - Latency from entering FETCH_HI to instr_valid=1: 2 cycles.
  - Best-case throughput: one instruction per 3 cycles.
- PC arithmetic is modulo 2^ADDR_W: pc=8'hFE advances to 8'h00. pc+1 for the low byte never carries because pc is always even.
- Branch handling:
  - branch_taken=1 in any state: pc<={branch_target[7:1],1'b0}; state<=FETCH_HI; instr_valid<=0.
  - Any partially fetched byte is discarded.
- Branch and handshake in the same cycle: if instr_valid&&instr_ready&&branch_taken, the transfer counts as completed and the redirect wins the pc update (no pc+2).
- Branch while not valid: no instruction is emitted for the discarded fetch.
- Reset mid-fetch: all state returns to reset values immediately; no instruction is emitted.

Optional Feature:
Macro FETCH_HALT_EN.
- With the macro: when FETCH_LO assembles 16'h0000, the word is not presented. instr_valid stays 0, halted<=1, state goes to HOLD, and pc freezes.
  - While halted: instr_ready is ignored.
  - branch_taken clears halted and redirects as normal.
  - reset clears halted.
- Without the macro: 16'h0000 is delivered like any other instruction, and halted is tied 0.

Decomposition:
- Package risc_fetch_pkg holds:
  - ADDR_W and INSTR_W localparams.
  - The fetch_state_t enum {FETCH_HI, FETCH_LO, HOLD}.
  - HALT_WORD=16'h0000.
- One natural sub-module: fetch_pc_reg, the PC register with increment-by-2, even-aligned load, and asynchronous reset to PC_RESET. The FSM and instruction assembly stay in the top level.

Test Plan:
- Memory bytes 0x03,0x45,0x04,0x65 at 0..3 with instr_ready=1 -> instr=16'h0345 at instr_pc=0, then 16'h0465 at instr_pc=2; instr_valid high exactly one cycle each, spaced 3 cycles apart.
- instr_ready=0 for 5 cycles on the first word -> instr=16'h0345 held stable with instr_valid=1; imem_addr does not advance past 0x00; word is accepted on the cycle ready rises.
- branch_taken=1 with branch_target=8'h07 during FETCH_LO of the word at 2 -> next instr is 16'h07D6 with instr_pc=6; word 0x0465 is never presented.
- PC_RESET=8'hFE, memory bytes 0xAB,0xCD at 0xFE..0xFF -> instr=16'hABCD at instr_pc=0xFE; next fetch address is 0x00.
- Reset asserted asynchronously mid-FETCH_LO -> instr_valid=0 and imem_addr=PC_RESET immediately, without waiting for a clock edge; fetch restarts cleanly.
- FETCH_HALT_EN defined, zero bytes at 10..11 -> after the word at pc=8, halted=1 and instr_valid stays 0; a branch to 0 clears halted and re-delivers 16'h0345.
